// File: rtl/clk_div_cfg_ctrl_pkg.sv
// Shared definitions for the clock-divider configuration sequencer:
// FSM state encoding, the reset-default ratio and the settle-counter sizing.
package clk_div_cfg_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_QUIESCE = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_ARM     = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam int DEFAULT_RATIO_C = 2;
  localparam int SETTLE_CYC_C    = 4;

  function automatic int settle_cnt_w(input int cyc);
    return $clog2(cyc + 1);
  endfunction

  localparam int SETTLE_W_C = settle_cnt_w(SETTLE_CYC_C);

endpackage

// File: rtl/clk_div_cfg_ctrl_if.sv
// Configuration request handshake between a request source (master)
// and the divider configuration sequencer (slave).
interface clk_div_cfg_ctrl_if #(
  parameter int RATIO_WD = 8
) ();

  logic                i_cfg_valid;
  logic                o_cfg_ready;
  logic [RATIO_WD-1:0] i_cfg_ratio;
  logic                i_cfg_enable;

  modport master (
    output i_cfg_valid,
    output i_cfg_ratio,
    output i_cfg_enable,
    input  o_cfg_ready
  );

  modport slave (
    input  i_cfg_valid,
    input  i_cfg_ratio,
    input  i_cfg_enable,
    output o_cfg_ready
  );

endinterface

// File: rtl/clk_div_cfg_ctrl_timer.sv
// Loadable down-counter shared by the settle wait and the one-period arm wait.
// Saturates at zero; expire is high in the last cycle of a loaded count.
module clk_div_cfg_timer
  import clk_div_cfg_pkg::*;
#(
  parameter int RATIO_WD = 8
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  input  logic                load,
  input  logic [RATIO_WD-1:0] load_val,
  output logic                expire
);

  logic [RATIO_WD-1:0] cnt;

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == RATIO_WD'(1));

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Sequencer owning the ratio/enable inputs of one integer clock divider.
// Optional range check on requested ratios: define CLK_DIV_CFG_CTRL_RANGE_CHK_EN.
module clk_div_cfg_ctrl
  import clk_div_cfg_pkg::*;
#(
  parameter int                  RATIO_WD      = 8,
  parameter int                  SETTLE_CYC    = 4,
  parameter logic [RATIO_WD-1:0] DEFAULT_RATIO = RATIO_WD'(DEFAULT_RATIO_C),
  parameter int                  MIN_RATIO     = 2,
  parameter int                  MAX_RATIO     = 255
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  clk_div_cfg_ctrl_if.slave   cfg,
  output logic [RATIO_WD-1:0] o_div_ratio,
  output logic                o_div_en,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int                  SETTLE_W = settle_cnt_w(SETTLE_CYC);
  localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE_CYC);

  if ((SETTLE_CYC < 1) || (SETTLE_CYC > 255) || (SETTLE_W > RATIO_WD)) begin : g_bad_settle
    $error("clk_div_cfg_ctrl: SETTLE_CYC out of range for RATIO_WD");
  end
  if (MIN_RATIO > MAX_RATIO) begin : g_bad_range
    $error("clk_div_cfg_ctrl: MIN_RATIO exceeds MAX_RATIO");
  end

  logic [2:0]          state;
  logic [RATIO_WD-1:0] shadow_ratio;
  logic                shadow_en;
  logic                accept;
  logic                same_cfg;
  logic                range_bad;
  logic                tmr_load;
  logic [RATIO_WD-1:0] tmr_val;
  logic                tmr_expire;

  assign accept   = cfg.i_cfg_valid && (state == ST_IDLE);
  assign same_cfg = (cfg.i_cfg_ratio == o_div_ratio) && (cfg.i_cfg_enable == o_div_en);

`ifdef CLK_DIV_CFG_CTRL_RANGE_CHK_EN
  localparam logic [RATIO_WD-1:0] MIN_R = RATIO_WD'(MIN_RATIO);
  localparam logic [RATIO_WD-1:0] MAX_R = RATIO_WD'(MAX_RATIO);
  logic err_q;

  assign range_bad = cfg.i_cfg_enable &&
                     ((cfg.i_cfg_ratio < MIN_R) || (cfg.i_cfg_ratio > MAX_R));

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst) err_q <= 1'b0;
    else        err_q <= accept && range_bad;
  end

  assign o_err = err_q;
`else
  assign range_bad = 1'b0;
  assign o_err     = 1'b0;
`endif

  // One timer serves both waits: settle count on entry to QUIESCE, ratio on LOAD.
  assign tmr_load = (accept && !range_bad && !same_cfg) || (state == ST_LOAD);
  assign tmr_val  = (state == ST_LOAD) ? shadow_ratio : RATIO_WD'(SETTLE_V);

  clk_div_cfg_timer #(
    .RATIO_WD (RATIO_WD)
  ) u_timer (
    .i_ref_clk (i_ref_clk),
    .i_rst     (i_rst),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .expire    (tmr_expire)
  );

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst) begin
      state        <= ST_IDLE;
      o_div_ratio  <= DEFAULT_RATIO;
      o_div_en     <= 1'b0;
      shadow_ratio <= '0;
      shadow_en    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shadow_ratio <= cfg.i_cfg_ratio;
            shadow_en    <= cfg.i_cfg_enable;
            if (range_bad) begin
              state <= ST_IDLE;
            end else if (same_cfg) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_QUIESCE;
              o_div_en <= 1'b0;
            end
          end
        end
        ST_QUIESCE: begin
          if (tmr_expire) begin
            state       <= ST_LOAD;
            o_div_ratio <= shadow_ratio;
          end
        end
        ST_LOAD: begin
          // Ratios 0 and 1 are bypass: loaded but never enabled.
          if (shadow_en && (shadow_ratio >= RATIO_WD'(2))) begin
            state    <= ST_ARM;
            o_div_en <= 1'b1;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_ARM: begin
          if (tmr_expire) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cfg.o_cfg_ready = (state == ST_IDLE);
  assign o_busy          = (state != ST_IDLE);
  assign o_done          = (state == ST_DONE);

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl: directed scenarios plus random
// requests checked cycle by cycle against a timeline model of each request.
module tb_clk_div_cfg_ctrl;

  localparam int SETTLE  = 4;
  localparam int MIN_R   = 4;
  localparam int MAX_R   = 255;
  localparam int DEF_R   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] div_ratio;
  logic       div_en, busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;
  int req_id = 0;

  logic [7:0] cur_r  = 8'(DEF_R);
  logic       cur_en = 1'b0;

  clk_div_cfg_ctrl_if #(.RATIO_WD(8)) cfg ();

  clk_div_cfg_ctrl #(
    .RATIO_WD      (8),
    .SETTLE_CYC    (SETTLE),
    .DEFAULT_RATIO (8'(DEF_R)),
    .MIN_RATIO     (MIN_R),
    .MAX_RATIO     (MAX_R)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst       (rst_n),
    .cfg         (cfg),
    .o_div_ratio (div_ratio),
    .o_div_en    (div_en),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ratio"}, div_ratio, cur_r);
    chk({tag, "_en"},    div_en,    cur_en);
    chk({tag, "_ready"}, cfg.o_cfg_ready, 1);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   err,  0);
  endtask

  // Issues one request at the current negedge (cycle 0) and checks every cycle
  // of its timeline. Expected outputs come from the request's event times:
  // settle ends after SETTLE cycles, ratio appears at SETTLE+1, enable at
  // SETTLE+2 and holds for one divided period, done one cycle after that.
  task automatic run_req(input logic [7:0] r, input logic e, input bit hold,
                         input logic [7:0] nr, input logic ne, input int stop_k);
    bit         ident, arm, rej;
    int         dk, last;
    logic [7:0] xr;
    logic       xen, xdone, xready, xbusy, xerr;
    req_id++;
    ident = (r == cur_r) && (e == cur_en);
    arm   = e && (r >= 8'd2);
    rej   = 1'b0;
`ifdef CLK_DIV_CFG_CTRL_RANGE_CHK_EN
    rej = e && ((int'(r) < MIN_R) || (int'(r) > MAX_R));
`endif
    dk   = ident ? 1 : SETTLE + 2 + (arm ? int'(r) : 0);
    last = rej ? 1 : dk + 1;
    cfg.i_cfg_valid  = 1'b1;
    cfg.i_cfg_ratio  = r;
    cfg.i_cfg_enable = e;
    chk($sformatf("req%0d_ready_c0", req_id), cfg.o_cfg_ready, 1);
    for (int k = 1; k <= last; k++) begin
      if (stop_k > 0 && k > stop_k) break;
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin
          cfg.i_cfg_ratio  = nr;
          cfg.i_cfg_enable = ne;
        end else begin
          cfg.i_cfg_valid = 1'b0;
        end
      end
      xerr = 1'b0;
      if (rej) begin
        xr = cur_r; xen = cur_en; xdone = 1'b0; xready = 1'b1; xbusy = 1'b0;
        xerr = (k == 1);
      end else if (ident) begin
        xr = cur_r; xen = cur_en; xdone = (k == 1); xready = (k >= 2);
        xbusy = (k == 1);
      end else begin
        xr     = (k >= SETTLE + 1) ? r : cur_r;
        xen    = arm && (k >= SETTLE + 2);
        xdone  = (k == dk);
        xready = (k > dk);
        xbusy  = (k <= dk);
      end
      chk($sformatf("req%0d_ratio_k%0d", req_id, k), div_ratio, xr);
      chk($sformatf("req%0d_en_k%0d",    req_id, k), div_en,    xen);
      chk($sformatf("req%0d_done_k%0d",  req_id, k), done,      xdone);
      chk($sformatf("req%0d_ready_k%0d", req_id, k), cfg.o_cfg_ready, xready);
      chk($sformatf("req%0d_busy_k%0d",  req_id, k), busy,      xbusy);
      chk($sformatf("req%0d_err_k%0d",   req_id, k), err,       xerr);
    end
    if (stop_k == 0 && !rej) begin
      cur_r  = r;
      cur_en = arm;
    end
  endtask

  initial begin
    logic [7:0] rr;
    logic       re;
    rst_n            = 1'b0;
    cfg.i_cfg_valid  = 1'b0;
    cfg.i_cfg_ratio  = '0;
    cfg.i_cfg_enable = 1'b0;

    // Reset held for three cycles, then released.
    repeat (3) @(negedge clk);
    chk_idle("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("after_reset");

    // Enabled change, identical repeat, bypass ratio.
    run_req(8'd6, 1'b1, 1'b0, 8'd0, 1'b0, 0);
    run_req(8'd6, 1'b1, 1'b0, 8'd0, 1'b0, 0);
    run_req(8'd1, 1'b1, 1'b0, 8'd0, 1'b0, 0);

    // Backpressure: next request held valid through the whole first sequence.
    run_req(8'd5, 1'b1, 1'b1, 8'd7, 1'b0, 0);
    run_req(8'd7, 1'b0, 1'b0, 8'd0, 1'b0, 0);

    // Reset abort while armed.
    run_req(8'd6, 1'b1, 1'b0, 8'd0, 1'b0, SETTLE + 3);
    rst_n = 1'b0;
    cfg.i_cfg_valid = 1'b0;
    @(negedge clk);
    cur_r  = 8'(DEF_R);
    cur_en = 1'b0;
    chk_idle("abort");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("abort_release");

    // Out-of-range ratio (rejected only with the range check built in).
    run_req(8'd9, 1'b1, 1'b0, 8'd0, 1'b0, 0);
    run_req(8'd3, 1'b1, 1'b0, 8'd0, 1'b0, 0);
    @(negedge clk);
    chk_idle("post_range");

    // Random requests, some repeating the current configuration.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rr = cur_r;
        re = cur_en;
      end else begin
        rr = 8'($urandom_range(0, 10));
        re = 1'($urandom_range(0, 1));
      end
      run_req(rr, re, 1'b0, 8'd0, 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
